// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared widths, op codes and FSM states for the mul/div sequencer
package muldiv_sequencer_pkg;
   localparam int WORD  = 32;
   localparam int DWORD = 64;
   typedef enum logic [1:0] {OP_MULT = 2'd0, OP_MULTU = 2'd1, OP_DIV = 2'd2, OP_DIVU = 2'd3} md_op_e;
   typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_CALC = 2'd1, MD_FIX = 2'd2, MD_WRITE = 2'd3} md_state_e;
   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: pipeline-side request/hi-lo bundle for the mul/div sequencer
interface muldiv_sequencer_if import muldiv_sequencer_pkg::*; ();
   logic             start;
   logic [1:0]       op;
   logic             cancel;
   logic             mt_hi;
   logic             mt_lo;
   logic [WORD-1:0]  rs_data;
   logic [WORD-1:0]  rt_data;
   logic [DWORD-1:0] hilo_q;
   logic             hilo_wr_en;
   logic [DWORD-1:0] hilo_wr_data;
   logic             busy;
   modport master (output start, op, cancel, mt_hi, mt_lo, rs_data, rt_data, hilo_q,
                   input hilo_wr_en, hilo_wr_data, busy);
   modport slave  (input start, op, cancel, mt_hi, mt_lo, rs_data, rt_data, hilo_q,
                   output hilo_wr_en, hilo_wr_data, busy);
endinterface

// File: rtl/muldiv_sequencer_sign.sv
// muldiv_sign: operand magnitudes on entry and conditional two's-complement negation on exit
module muldiv_sign import muldiv_sequencer_pkg::*; (
   input  logic             i_signed,
   input  logic [WORD-1:0]  i_rs,
   input  logic [WORD-1:0]  i_rt,
   output logic [WORD-1:0]  o_rs_mag,
   output logic [WORD-1:0]  o_rt_mag,
   input  logic [DWORD-1:0] i_val,
   input  logic             i_neg_dw,
   input  logic             i_neg_hi,
   input  logic             i_neg_lo,
   output logic [DWORD-1:0] o_val
);
   logic [WORD-1:0] w_hi, w_lo;
   assign o_rs_mag = (i_signed && i_rs[WORD-1]) ? -i_rs : i_rs;
   assign o_rt_mag = (i_signed && i_rt[WORD-1]) ? -i_rt : i_rt;
   assign w_hi     = i_neg_hi ? -i_val[DWORD-1:WORD] : i_val[DWORD-1:WORD];
   assign w_lo     = i_neg_lo ? -i_val[WORD-1:0] : i_val[WORD-1:0];
   assign o_val    = i_neg_dw ? -i_val : {w_hi, w_lo};
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: 34-cycle iterative MULT/MULTU/DIV/DIVU with hi/lo write port and MTHI/MTLO merge
module muldiv_sequencer import muldiv_sequencer_pkg::*; (
   input logic              clk_cpu,
   input logic              reset,
   muldiv_sequencer_if.slave md
);
   md_state_e        r_state;
   md_op_e           r_op;
   logic [4:0]       r_cnt;
   logic [WORD-1:0]  r_hi, r_lo, r_b;
   logic             r_sa, r_sb, r_dz, r_busy, r_wr_en;
   logic [DWORD-1:0] r_wr_data;
   logic             w_go, w_mt, w_is_mul, w_sgn, w_ge;
   logic [WORD-1:0]  w_rs_mag, w_rt_mag, w_sub;
   logic [WORD:0]    w_add, w_sh;
   logic [DWORD-1:0] w_mul_nxt, w_div_nxt, w_fix;

   assign w_go     = md.start & ~md.cancel;
   assign w_is_mul = ~r_op[1];
   assign w_sgn    = is_signed_op(r_op);

   // shift-add: hi accumulates, lo shifts out multiplier bits and shifts in product bits
   assign w_add     = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_b}) : {1'b0, r_hi};
   assign w_mul_nxt = {w_add, r_lo[WORD-1:1]};
   // restoring divide: partial remainder in hi, dividend/quotient in lo
   assign w_sh      = {r_hi, r_lo[WORD-1]};
   assign w_ge      = w_sh >= {1'b0, r_b};
   assign w_sub     = w_sh[WORD-1:0] - r_b;
   assign w_div_nxt = {w_ge ? w_sub : w_sh[WORD-1:0], r_lo[WORD-2:0], w_ge};

   muldiv_sign u_sign (
      .i_signed (is_signed_op(md.op)),
      .i_rs     (md.rs_data),
      .i_rt     (md.rt_data),
      .o_rs_mag (w_rs_mag),
      .o_rt_mag (w_rt_mag),
      .i_val    ({r_hi, r_lo}),
      .i_neg_dw (w_is_mul & w_sgn & (r_sa ^ r_sb)),
      .i_neg_hi (~w_is_mul & w_sgn & r_sa),
      .i_neg_lo (~w_is_mul & w_sgn & (r_sa ^ r_sb)),
      .o_val    (w_fix)
   );

   always_ff @(posedge clk_cpu or posedge reset) begin
      if (reset) begin
         r_state   <= MD_IDLE;
         r_op      <= OP_MULT;
         r_cnt     <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_b       <= '0;
         r_sa      <= 1'b0;
         r_sb      <= 1'b0;
         r_dz      <= 1'b0;
         r_busy    <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else begin
         case (r_state)
            MD_IDLE: if (w_go) begin
               r_state <= MD_CALC;
               r_op    <= md_op_e'(md.op);
               r_cnt   <= '0;
               r_hi    <= '0;
               r_lo    <= w_rs_mag;
               r_b     <= w_rt_mag;
               r_sa    <= md.rs_data[WORD-1];
               r_sb    <= md.rt_data[WORD-1];
               r_dz    <= md.op[1] & (md.rt_data == '0);
               r_busy  <= 1'b1;
            end
            MD_CALC: if (md.cancel) begin
               r_state <= MD_IDLE;
               r_busy  <= 1'b0;
            end else begin
               {r_hi, r_lo} <= w_is_mul ? w_mul_nxt : w_div_nxt;
               r_cnt        <= r_cnt + 5'd1;
               r_state      <= (r_cnt == 5'd31) ? MD_FIX : MD_CALC;
            end
            MD_FIX: if (md.cancel) begin
               r_state <= MD_IDLE;
               r_busy  <= 1'b0;
            end else begin
               // divisor 0 leaves the dividend as remainder; only the quotient needs forcing
               r_state   <= MD_WRITE;
               r_wr_en   <= 1'b1;
               r_wr_data <= r_dz ? {w_fix[DWORD-1:WORD], {WORD{1'b1}}} : w_fix;
            end
            default: begin
               r_state   <= MD_IDLE;
               r_busy    <= 1'b0;
               r_wr_en   <= 1'b0;
               r_wr_data <= '0;
            end
         endcase
      end
   end

   assign w_mt            = (r_state == MD_IDLE) & ~w_go & (md.mt_hi | md.mt_lo);
   assign md.hilo_wr_en   = r_wr_en | w_mt;
   assign md.hilo_wr_data = !w_mt ? r_wr_data :
                            md.mt_hi ? {md.rs_data, md.hilo_q[WORD-1:0]} : {md.hilo_q[DWORD-1:WORD], md.rs_data};
   assign md.busy         = r_busy;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random mul/div/MT checks against an arithmetic reference model
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;
   logic        clk_cpu = 1'b0;
   logic        reset   = 1'b1;
   logic [63:0] hilo_reg = '0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          wr_total = 0;

   muldiv_sequencer_if mdif ();
   muldiv_sequencer dut (.clk_cpu(clk_cpu), .reset(reset), .md(mdif));

   always #5 clk_cpu = ~clk_cpu;
   assign mdif.hilo_q = hilo_reg;
   always @(posedge clk_cpu) begin
      if (mdif.hilo_wr_en) begin
         hilo_reg <= mdif.hilo_wr_data;
         wr_total <= wr_total + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (o[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
      case (o)
         2'd0: return 64'(sa * sb);
         2'd1: return ua * ub;
         2'd2: begin q = 64'(sa / sb); r = 64'(sa % sb); end
         default: begin q = ua / ub; r = ua % ub; end
      endcase
      return {r[31:0], q[31:0]};
   endfunction

   // inj: 0 none, 1 start+mt_hi mid-CALC, 2 cancel during the WRITE cycle
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int inj);
      logic [63:0] exp, data;
      int          cyc, nwr, at;
      bit          zok;
      exp = ref_md(o, a, b);
      @(negedge clk_cpu);
      mdif.op = o; mdif.rs_data = a; mdif.rt_data = b; mdif.start = 1'b1;
      @(posedge clk_cpu); #1;
      mdif.start = 1'b0;
      cyc = 0; nwr = 0; at = -1; data = '0; zok = 1'b1;
      while (mdif.busy && cyc < 40) begin
         if (mdif.hilo_wr_en) begin nwr++; at = cyc; data = mdif.hilo_wr_data; end
         else if (mdif.hilo_wr_data != 64'd0) zok = 1'b0;
         @(negedge clk_cpu);
         if (inj == 1 && cyc == 5) begin
            mdif.start = 1'b1; mdif.mt_hi = 1'b1; mdif.op = 2'($urandom);
            mdif.rs_data = $urandom; mdif.rt_data = $urandom;
         end
         if (inj == 2 && cyc == 33) mdif.cancel = 1'b1;
         @(posedge clk_cpu); #1;
         mdif.start = 1'b0; mdif.mt_hi = 1'b0; mdif.cancel = 1'b0;
         cyc++;
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'd34);
      check({tag, "_wr_count"}, 64'(nwr), 64'd1);
      check({tag, "_wr_cycle"}, 64'(at), 64'd33);
      check({tag, "_wr_data"}, data, exp);
      check({tag, "_idle_data_zero"}, 64'(zok), 64'd1);
      check({tag, "_hilo"}, hilo_reg, exp);
   endtask

   task automatic mt_req(input string tag, input bit h, input bit l, input logic [31:0] a, input logic [63:0] exp);
      @(negedge clk_cpu);
      mdif.mt_hi = h; mdif.mt_lo = l; mdif.rs_data = a;
      #1;
      check({tag, "_en"}, 64'(mdif.hilo_wr_en), 64'd1);
      check({tag, "_data"}, mdif.hilo_wr_data, exp);
      @(posedge clk_cpu); #1;
      mdif.mt_hi = 1'b0; mdif.mt_lo = 1'b0;
      check({tag, "_hilo"}, hilo_reg, exp);
   endtask

   task automatic abort_op(input string tag, input bit use_reset);
      int          t0;
      logic [63:0] h0;
      @(negedge clk_cpu);
      mdif.op = OP_MULTU; mdif.rs_data = 32'h1357_9BDF; mdif.rt_data = 32'h2468_ACE0; mdif.start = 1'b1;
      @(posedge clk_cpu); #1;
      mdif.start = 1'b0;
      repeat (10) @(posedge clk_cpu);
      h0 = hilo_reg;
      @(negedge clk_cpu);
      t0 = wr_total;
      if (use_reset) begin
         #2 reset = 1'b1;
         #1;
         check({tag, "_busy_now"}, 64'(mdif.busy), 64'd0);
         check({tag, "_wr_en_now"}, 64'(mdif.hilo_wr_en), 64'd0);
         @(negedge clk_cpu);
         reset = 1'b0;
      end else begin
         mdif.cancel = 1'b1;
         @(posedge clk_cpu); #1;
         mdif.cancel = 1'b0;
         check({tag, "_busy_next"}, 64'(mdif.busy), 64'd0);
      end
      repeat (40) @(posedge clk_cpu);
      #1;
      check({tag, "_no_write"}, 64'(wr_total - t0), 64'd0);
      check({tag, "_hilo_kept"}, hilo_reg, h0);
      check({tag, "_idle"}, 64'(mdif.busy), 64'd0);
   endtask

   initial begin
      logic [31:0] corner [6];
      logic [31:0] a, b;
      int          k;
      corner = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      mdif.start = 1'b0; mdif.op = '0; mdif.cancel = 1'b0; mdif.mt_hi = 1'b0; mdif.mt_lo = 1'b0;
      mdif.rs_data = '0; mdif.rt_data = '0;
      #1;
      check("reset_busy", 64'(mdif.busy), 64'd0);
      check("reset_wr_en", 64'(mdif.hilo_wr_en), 64'd0);
      check("reset_wr_data", mdif.hilo_wr_data, 64'd0);
      @(negedge clk_cpu);
      reset = 1'b0;

      run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("multu_max_lit", hilo_reg, 64'hFFFF_FFFE_0000_0001);
      run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 0);
      check("mult_neg_lit", hilo_reg, 64'hFFFF_FFFF_FFFF_FFF1);
      run_op("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
      check("mult_min_lit", hilo_reg, 64'h4000_0000_0000_0000);
      run_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
      check("div_neg_lit", hilo_reg, 64'hFFFF_FFFF_FFFF_FFFD);
      run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 0);
      check("divu_7_2_lit", hilo_reg, 64'h0000_0001_0000_0003);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_ovf_lit", hilo_reg, 64'h0000_0000_8000_0000);
      run_op("divu_zero", OP_DIVU, 32'h1234, 32'd0, 0);
      check("divu_zero_lit", hilo_reg, 64'h0000_1234_FFFF_FFFF);
      run_op("div_zero_neg", OP_DIV, 32'hFFFF_FF00, 32'd0, 0);
      run_op("mid_start", OP_MULT, 32'h0001_2345, 32'hFFFF_0003, 1);
      run_op("cancel_write", OP_DIVU, 32'hDEAD_BEEF, 32'd1000, 2);
      run_op("back_to_back", OP_DIV, 32'h0000_0064, 32'hFFFF_FFF9, 0);

      abort_op("cancel_calc", 1'b0);
      abort_op("reset_calc", 1'b1);

      mt_req("mt_hi_fill", 1'b1, 1'b0, 32'hAAAA_AAAA, {32'hAAAA_AAAA, hilo_reg[31:0]});
      mt_req("mt_lo_fill", 1'b0, 1'b1, 32'h5555_5555, 64'hAAAA_AAAA_5555_5555);
      mt_req("mt_hi", 1'b1, 1'b0, 32'h0000_1234, 64'h0000_1234_5555_5555);
      mt_req("mt_both", 1'b1, 1'b1, 32'h0BAD_F00D, 64'h0BAD_F00D_5555_5555);
      mt_req("mt_lo", 1'b0, 1'b1, 32'hCAFE_0001, 64'h0BAD_F00D_CAFE_0001);

      @(negedge clk_cpu);
      mdif.op = OP_MULTU; mdif.rs_data = 32'd2; mdif.rt_data = 32'd3; mdif.start = 1'b1; mdif.mt_lo = 1'b1;
      #1;
      check("start_mt_drop_en", 64'(mdif.hilo_wr_en), 64'd0);
      @(posedge clk_cpu); #1;
      mdif.start = 1'b0; mdif.mt_lo = 1'b0;
      k = 0;
      while (mdif.busy && k < 40) begin @(posedge clk_cpu); #1; k++; end
      check("start_mt_cycles", 64'(k), 64'd34);
      check("start_mt_hilo", hilo_reg, 64'd6);

      for (int i = 0; i < 16; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         run_op("rand", 2'($urandom_range(0, 3)), a, b, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
